csr_timer: RTL and testbench
============================

# csr_timer

Constant-count CSR timer that produces `csr_timer_intr_sync`, the timer interrupt level consumed by the interrupt controller (`pic`). It holds the TCFG configuration, a TVAL down-counter and the timer-interrupt (TI) pending bit. TI is set when the counter expires and is cleared by a TICLR write from the interrupt handler. CSR address decode is done upstream; this block receives decoded write strobes and returns read data to the CSR read mux.

## Interface
- `TIMER_W`, default 32: counter and InitVal width; legal range 4..32.

Ports, listed as name, direction, width, meaning:
- `clk` input 1: core clock.
- `resetn` input 1: asynchronous, active-low reset.
- `tcfg_wen` input 1: write strobe for TCFG.
- `tcfg_wdata` input 32: TCFG write data. Bit 0 is En, bit 1 is Periodic, bits [TIMER_W-1:2] are InitVal.
- `ticlr_wen` input 1: write strobe for TICLR.
- `ticlr_wdata` input 32: bit 0 = CLR. All other bits are ignored.
- `tcfg_rdata` output 32: current TCFG, bits [TIMER_W-1:0], zero-extended.
- `tval_rdata` output 32: current counter value, zero-extended.
- `csr_timer_intr_sync` output 1: registered TI pending level, fed to `pic`.

## Operation
- Reset values:
  - TCFG = 0.
  - Counter = all ones (TIMER_W bits).
  - TI = 0.
  - State = IDLE.
  - All outputs read 0, except `tval_rdata`, which reads all ones in the low TIMER_W bits.
- The state machine has three states: IDLE, COUNT and EXPIRED.
- TCFG write, from any state:
  - TCFG is loaded with `tcfg_wdata[TIMER_W-1:0]`.
  - The counter is loaded with {InitVal, 2'b00}.
  - Next state is COUNT if En=1, otherwise IDLE.
- IDLE: the counter holds.
- COUNT, counter ≠ 0: counter decrements by 1 per cycle.
- COUNT, counter = 0:
  - TI is set.
  - If Periodic=1: the counter reloads {InitVal, 2'b00} and the state stays COUNT.
  - If Periodic=0: the counter becomes all ones and the state moves to EXPIRED.
- EXPIRED: the counter holds at all ones and TI is not set again. Leaving EXPIRED requires a TCFG write.
- TICLR write with CLR=1 clears TI. A write with CLR=0 has no effect.
- Arithmetic: decrement is modulo 2^TIMER_W, but 0 never decrements because the expiry rule takes priority.
- InitVal = 0 with En=1:
  - Expiry occurs on the first COUNT cycle.
  - In periodic mode TI is set every cycle.
- Simultaneous events:
  - Expiry together with TICLR CLR=1: the set wins, so TI stays 1 and the new event is not lost.
  - TCFG write together with expiry: the expiry is evaluated on the old counter and TI is still set. The counter and state take the TCFG write values.
  - TCFG write together with TICLR: both take effect.
- TI is not cleared by a TCFG write or by En=0. Only TICLR or reset clears it.
- Asynchronous reset mid-count immediately forces all reset values. No partial state survives.

## Timing
- Write-to-read:
  - TCFG written in cycle 0 reads back on `tcfg_rdata` in cycle 1.
  - The loaded counter appears on `tval_rdata` in cycle 1.
- Expiry latency:
  - For a TCFG write in cycle 0 with count value C = InitVal·4, the counter reads C in cycle 1 and 0 in cycle C+1.
  - `csr_timer_intr_sync` rises in cycle C+2.
- Periodic mode: TI set events are spaced C+1 cycles apart.
- TICLR written in cycle k drops `csr_timer_intr_sync` in cycle k+1, unless an expiry also occurs in cycle k.
- `csr_timer_intr_sync` is a registered output with no combinational path from any input. The block has no handshakes: strobes are single-cycle and always accepted.

## Structure
- Shared CSR package holds:
  - TCFG field positions (EN=0, PERIODIC=1, INITVAL_LSB=2).
  - TICLR CLR bit position.
  - State encoding (IDLE, COUNT, EXPIRED).
  - CSR numbers TCFG=0x41, TVAL=0x42, TICLR=0x44, used by the upstream decoder.
- All state uses the codebase's asynchronous active-low reset flops.
- No sub-module: the counter, state register and TI flop are small enough to live flat in `csr_timer`.

## Test plan
- One-shot:
  - Stimulus: TCFG=0x21 (InitVal=8, En=1) in cycle 0.
  - Response: `tval_rdata` reads 32,31,…,0 in cycles 1..33. TI rises in cycle 34. Counter reads 0xFFFFFFFF from cycle 34 onward. TI never re-sets.
- Periodic:
  - Stimulus: TCFG=0x0B (InitVal=2, En=1, Periodic=1), then TICLR=1 issued 2 cycles after each TI rise.
  - Response: TI rises every 9 cycles and clears the cycle after each TICLR.
- Clear/set collision:
  - Stimulus: TICLR=1 issued in the same cycle the counter reads 0 (periodic mode).
  - Response: TI remains 1.
- Disable and reprogram:
  - Stimulus: TCFG=0x00 written mid-count with TI already 1.
  - Response: counter freezes at 0, TI stays 1 until TICLR. A subsequent TCFG=0x05 expires with TI rising 6 cycles after the write.
- Reset mid-count:
  - Stimulus: `resetn` deasserted asynchronously mid-count (between clock edges).
  - Response: TCFG=0, TI=0, counter all ones immediately, with no further TI after release.
- InitVal=0 periodic:
  - Stimulus: TCFG=0x03.
  - Response: TI set from cycle 2 onward, and re-set every cycle despite continuous TICLR.

Source files
------------

// File: rtl/csr_timer_pkg.sv
// Shared CSR definitions for the constant-count timer: field positions,
// FSM state encoding and CSR numbers used by the upstream decoder.
package csr_timer_pkg;

  localparam int TCFG_EN          = 0;
  localparam int TCFG_PERIODIC    = 1;
  localparam int TCFG_INITVAL_LSB = 2;

  localparam int TICLR_CLR = 0;

  localparam logic [13:0] CSR_TCFG  = 14'h041;
  localparam logic [13:0] CSR_TVAL  = 14'h042;
  localparam logic [13:0] CSR_TICLR = 14'h044;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

endpackage

// File: rtl/csr_timer.sv
// CSR timer: TCFG register, TVAL down-counter and TI pending flop driving
// the registered interrupt level csr_timer_intr_sync.
module csr_timer
  import csr_timer_pkg::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        tcfg_wen,
  input  logic [31:0] tcfg_wdata,
  input  logic        ticlr_wen,
  input  logic [31:0] ticlr_wdata,
  output logic [31:0] tcfg_rdata,
  output logic [31:0] tval_rdata,
  output logic        csr_timer_intr_sync
);

  logic [TIMER_W-1:0] tcfg_reg;
  logic [TIMER_W-1:0] cnt_reg;
  logic [TIMER_W-1:0] load_val;
  logic [TIMER_W-1:0] reload_val;
  state_t             state_reg;
  logic               ti_reg;
  logic               expire;
  logic               ti_clr;
  logic               unused_bits;

  assign load_val   = {tcfg_wdata[TIMER_W-1:TCFG_INITVAL_LSB], 2'b00};
  assign reload_val = {tcfg_reg[TIMER_W-1:TCFG_INITVAL_LSB], 2'b00};
  // Expiry is judged on the pre-write counter, so a same-cycle TCFG write
  // still lets TI be set.
  assign expire     = (state_reg == ST_COUNT) && (cnt_reg == '0);
  assign ti_clr     = ticlr_wen && ticlr_wdata[TICLR_CLR];
  assign unused_bits = ^{ticlr_wdata[31:1], tcfg_wdata};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tcfg_reg  <= '0;
      cnt_reg   <= '1;
      ti_reg    <= 1'b0;
      state_reg <= ST_IDLE;
    end else begin
      // A new expiry beats a simultaneous clear so the event is not lost.
      if (expire) begin
        ti_reg <= 1'b1;
      end else if (ti_clr) begin
        ti_reg <= 1'b0;
      end

      if (tcfg_wen) begin
        tcfg_reg  <= tcfg_wdata[TIMER_W-1:0];
        cnt_reg   <= load_val;
        state_reg <= tcfg_wdata[TCFG_EN] ? ST_COUNT : ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            cnt_reg <= cnt_reg;
          end
          ST_COUNT: begin
            if (cnt_reg != '0) begin
              cnt_reg <= cnt_reg - 1'b1;
            end else if (tcfg_reg[TCFG_PERIODIC]) begin
              cnt_reg <= reload_val;
            end else begin
              cnt_reg   <= '1;
              state_reg <= ST_EXPIRED;
            end
          end
          ST_EXPIRED: begin
            cnt_reg <= '1;
          end
          default: begin
            cnt_reg   <= '1;
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign tcfg_rdata          = 32'(tcfg_reg);
  assign tval_rdata          = 32'(cnt_reg);
  assign csr_timer_intr_sync = ti_reg;

endmodule

// File: tb/tb_csr_timer.sv
// Bench for csr_timer: directed scenarios plus random traffic, checked every
// cycle against a timeline model (counter value derived from cycles-since-write).
module tb_csr_timer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        tcfg_wen = 1'b0;
  logic [31:0] tcfg_wdata = '0;
  logic        ticlr_wen = 1'b0;
  logic [31:0] ticlr_wdata = '0;
  logic [31:0] tcfg_rdata;
  logic [31:0] tval_rdata;
  logic        csr_timer_intr_sync;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  csr_timer #(.TIMER_W(32)) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .tcfg_wen            (tcfg_wen),
    .tcfg_wdata          (tcfg_wdata),
    .ticlr_wen           (ticlr_wen),
    .ticlr_wdata         (ticlr_wdata),
    .tcfg_rdata          (tcfg_rdata),
    .tval_rdata          (tval_rdata),
    .csr_timer_intr_sync (csr_timer_intr_sync)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Timeline model: after a TCFG write the counter is a closed-form function
  // of the number of cycles since the write.
  logic [31:0] cfg_m;
  longint      c_m;
  longint      age_m;
  bit          en_m, per_m, hold_ones_m;
  bit          ti_m;

  function automatic logic [31:0] cnt_now();
    if (hold_ones_m) return '1;
    if (!en_m) return 32'(c_m);
    if (per_m) return 32'(c_m - ((age_m - 1) % (c_m + 1)));
    if (age_m <= c_m + 1) return 32'(c_m - (age_m - 1));
    return '1;
  endfunction

  function automatic bit expire_now();
    if (hold_ones_m || !en_m) return 1'b0;
    if (per_m) return ((age_m - 1) % (c_m + 1)) == c_m;
    return age_m == c_m + 1;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cfg_m       <= '0;
      c_m         <= 0;
      age_m       <= 0;
      en_m        <= 1'b0;
      per_m       <= 1'b0;
      hold_ones_m <= 1'b1;
      ti_m        <= 1'b0;
    end else begin
      if (expire_now()) ti_m <= 1'b1;
      else if (ticlr_wen && ticlr_wdata[0]) ti_m <= 1'b0;
      if (tcfg_wen) begin
        cfg_m       <= tcfg_wdata;
        c_m         <= longint'(tcfg_wdata & 32'hFFFF_FFFC);
        en_m        <= tcfg_wdata[0];
        per_m       <= tcfg_wdata[1];
        hold_ones_m <= 1'b0;
        age_m       <= 1;
      end else begin
        age_m <= age_m + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      chk("model_tcfg", tcfg_rdata, cfg_m);
      chk("model_tval", tval_rdata, cnt_now());
      chk("model_intr", 32'(csr_timer_intr_sync), 32'(ti_m));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_tcfg(input logic [31:0] d);
    tcfg_wen = 1'b1;
    tcfg_wdata = d;
    tick();
    tcfg_wen = 1'b0;
  endtask

  task automatic clr_ti();
    ticlr_wen = 1'b1;
    ticlr_wdata = 32'h1;
    tick();
    ticlr_wen = 1'b0;
    ticlr_wdata = '0;
  endtask

  task automatic wait_rise(output int at);
    int n = 0;
    while (!csr_timer_intr_sync && n < 100) begin
      tick();
      n++;
    end
    chk("rise_timeout", 32'(n < 100), 32'h1);
    at = cyc;
  endtask

  initial begin
    int r1, r2, n;
    logic [31:0] d;

    repeat (3) @(posedge clk);
    #3 resetn = 1'b1;
    tick();
    chk("reset_tcfg", tcfg_rdata, 32'h0);
    chk("reset_tval", tval_rdata, 32'hFFFF_FFFF);
    chk("reset_intr", 32'(csr_timer_intr_sync), 32'h0);
    $display("[TB] reset checked");

    // One-shot, InitVal=8
    wr_tcfg(32'h21);
    chk("oneshot_c1", tval_rdata, 32'd32);
    chk("oneshot_tcfg", tcfg_rdata, 32'h21);
    repeat (32) tick();
    chk("oneshot_zero", tval_rdata, 32'd0);
    chk("oneshot_intr_pre", 32'(csr_timer_intr_sync), 32'h0);
    tick();
    chk("oneshot_intr_rise", 32'(csr_timer_intr_sync), 32'h1);
    chk("oneshot_ones", tval_rdata, 32'hFFFF_FFFF);
    repeat (20) tick();
    chk("oneshot_hold", tval_rdata, 32'hFFFF_FFFF);
    clr_ti();
    chk("oneshot_clr", 32'(csr_timer_intr_sync), 32'h0);
    repeat (20) tick();
    chk("oneshot_no_reset", 32'(csr_timer_intr_sync), 32'h0);
    $display("[TB] one-shot done");

    // Periodic, InitVal=2: period 9
    wr_tcfg(32'h0B);
    wait_rise(r1);
    for (int i = 0; i < 3; i++) begin
      tick();
      tick();
      clr_ti();
      chk("periodic_clr", 32'(csr_timer_intr_sync), 32'h0);
      wait_rise(r2);
      chk("periodic_spacing", 32'(r2 - r1), 32'd9);
      $display("[TB] periodic rise at %0d spacing %0d", r2, r2 - r1);
      r1 = r2;
    end

    // Clear colliding with expiry
    clr_ti();
    n = 0;
    while (tval_rdata != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("collide_timeout", 32'(n < 100), 32'h1);
    chk("collide_intr_pre", 32'(csr_timer_intr_sync), 32'h0);
    clr_ti();
    chk("collide_set_wins", 32'(csr_timer_intr_sync), 32'h1);
    $display("[TB] collision done");

    // Disable mid-count with TI set, then reprogram InitVal=1
    repeat (3) tick();
    wr_tcfg(32'h00);
    repeat (5) tick();
    chk("disable_freeze", tval_rdata, 32'd0);
    chk("disable_ti_kept", 32'(csr_timer_intr_sync), 32'h1);
    clr_ti();
    chk("disable_clr", 32'(csr_timer_intr_sync), 32'h0);
    wr_tcfg(32'h05);
    repeat (4) tick();
    chk("reprog_pre", 32'(csr_timer_intr_sync), 32'h0);
    tick();
    chk("reprog_rise6", 32'(csr_timer_intr_sync), 32'h1);
    $display("[TB] disable/reprogram done");

    // Asynchronous reset mid-count
    wr_tcfg(32'h21);
    repeat (5) tick();
    #2 resetn = 1'b0;
    #1;
    chk("async_tcfg", tcfg_rdata, 32'h0);
    chk("async_tval", tval_rdata, 32'hFFFF_FFFF);
    chk("async_intr", 32'(csr_timer_intr_sync), 32'h0);
    repeat (2) tick();
    #2 resetn = 1'b1;
    repeat (50) tick();
    chk("async_no_ti", 32'(csr_timer_intr_sync), 32'h0);
    $display("[TB] async reset done");

    // InitVal=0 periodic with continuous clear
    wr_tcfg(32'h03);
    ticlr_wen = 1'b1;
    ticlr_wdata = 32'h1;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("iv0_always_set", 32'(csr_timer_intr_sync), 32'h1);
      tick();
    end
    ticlr_wen = 1'b0;
    ticlr_wdata = '0;
    $display("[TB] initval0 periodic done");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      d = $urandom;
      d[31:5] = '0;
      tcfg_wen = ($urandom_range(0, 15) == 0);
      tcfg_wdata = d;
      ticlr_wen = ($urandom_range(0, 5) == 0);
      ticlr_wdata = $urandom;
      tick();
    end
    tcfg_wen = 1'b0;
    ticlr_wen = 1'b0;
    tick();
    $display("[TB] random traffic done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
